// File: rtl/spi_input_conditioner.sv
// Purpose: synchronize, debounce and edge-detect the asynchronous SPI pins (MOSI, SCLK, CS) into clk.
// Latency: a pin change held stable reaches *_cond and its edge pulse WAITTIME+2 edges after it is first sampled.
// Backpressure: none; every output is a free-running registered level or a one-cycle pulse.
module spi_input_conditioner #(
  parameter int COUNTERWIDTH = 3,
  parameter int WAITTIME     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic mosi_pin,
  input  logic sclk_pin,
  input  logic cs_pin,
  output logic mosi_cond,
  output logic mosi_posedge,
  output logic mosi_negedge,
  output logic sclk_cond,
  output logic sclk_posedge,
  output logic sclk_negedge,
  output logic cs_cond,
  output logic cs_posedge,
  output logic cs_negedge
);

  // Channel order: 0 = MOSI, 1 = SCLK, 2 = CS. CS idles high so it comes out of reset deasserted.
  localparam logic [2:0] RST_LEVEL = 3'b100;
  localparam logic [COUNTERWIDTH-1:0] WAIT_CNT = COUNTERWIDTH'(WAITTIME);

  logic [2:0] pin_vec;
  logic [2:0] cond_vec;
  logic [2:0] pos_vec;
  logic [2:0] neg_vec;

  assign pin_vec = {cs_pin, sclk_pin, mosi_pin};

  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic                    sync1;
    logic                    sync2;
    logic                    cond;
    logic                    pos_q;
    logic                    neg_q;
    logic [COUNTERWIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1 <= RST_LEVEL[g];
        sync2 <= RST_LEVEL[g];
        cond  <= RST_LEVEL[g];
        cnt   <= '0;
        pos_q <= 1'b0;
        neg_q <= 1'b0;
      end else begin
        sync1 <= pin_vec[g];
        sync2 <= sync1;
        pos_q <= 1'b0;
        neg_q <= 1'b0;
        if (sync2 == cond) begin
          cnt <= '0;
        end else if (cnt != WAIT_CNT) begin
          cnt <= cnt + 1'b1;
        end else begin
          // Level held long enough: commit it and flag the direction for one cycle.
          cond  <= sync2;
          cnt   <= '0;
          pos_q <= sync2;
          neg_q <= ~sync2;
        end
      end
    end

    assign cond_vec[g] = cond;
    assign pos_vec[g]  = pos_q;
    assign neg_vec[g]  = neg_q;
  end

  assign mosi_cond    = cond_vec[0];
  assign mosi_posedge = pos_vec[0];
  assign mosi_negedge = neg_vec[0];
  assign sclk_cond    = cond_vec[1];
  assign sclk_posedge = pos_vec[1];
  assign sclk_negedge = neg_vec[1];
  assign cs_cond      = cond_vec[2];
  assign cs_posedge   = pos_vec[2];
  assign cs_negedge   = neg_vec[2];

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Bench for spi_input_conditioner with default parameters: table of per-cycle vectors plus multi-cycle sequences.
module tb_spi_input_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mosi_pin = 1'b0;
  logic sclk_pin = 1'b0;
  logic cs_pin = 1'b1;
  logic mosi_cond, mosi_posedge, mosi_negedge;
  logic sclk_cond, sclk_posedge, sclk_negedge;
  logic cs_cond, cs_posedge, cs_negedge;

  spi_input_conditioner #(.COUNTERWIDTH(3), .WAITTIME(3)) dut (
    .clk(clk), .reset(reset),
    .mosi_pin(mosi_pin), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
    .mosi_cond(mosi_cond), .mosi_posedge(mosi_posedge), .mosi_negedge(mosi_negedge),
    .sclk_cond(sclk_cond), .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
    .cs_cond(cs_cond), .cs_posedge(cs_posedge), .cs_negedge(cs_negedge)
  );

  always #5 clk = ~clk;

  // Output bundle: {mosi cond,pos,neg, sclk cond,pos,neg, cs cond,pos,neg}
  logic [8:0] outv;
  assign outv = {mosi_cond, mosi_posedge, mosi_negedge,
                 sclk_cond, sclk_posedge, sclk_negedge,
                 cs_cond, cs_posedge, cs_negedge};

  localparam logic [8:0] IDLE = 9'b000_000_100;

  typedef struct {
    logic       mosi;
    logic       sclk;
    logic       cs;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int n_csn, n_csp, n_sp, n_sn, n_viol;

  task automatic add(input logic m, input logic s, input logic c, input logic [8:0] e, input int n);
    vec_t v;
    v.mosi = m; v.sclk = s; v.cs = c; v.exp = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_cnt();
    tick();
    n_csn += int'(cs_negedge);
    n_csp += int'(cs_posedge);
    n_sp  += int'(sclk_posedge);
    n_sn  += int'(sclk_negedge);
    if ((sclk_posedge || sclk_negedge) && cs_cond !== 1'b0) n_viol++;
  endtask

  task automatic reset_idle();
    mosi_pin = 1'b0; sclk_pin = 1'b0; cs_pin = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    int idx_m, idx_s, cs_pulses, cs_bad;

    // Quiet after reset release with pins at idle levels.
    add(0, 0, 1, IDLE, 10);
    // Clean SCLK rise then fall: pulse on the 6th edge after the change.
    add(0, 1, 1, IDLE, 5);
    add(0, 1, 1, 9'b000_110_100, 1);
    add(0, 1, 1, 9'b000_100_100, 3);
    add(0, 0, 1, 9'b000_100_100, 5);
    add(0, 0, 1, 9'b000_001_100, 1);
    add(0, 0, 1, IDLE, 3);
    // 3-cycle MOSI glitch is filtered.
    add(1, 0, 1, IDLE, 3);
    add(0, 0, 1, IDLE, 7);
    // 4-cycle MOSI pulse commits high then low.
    add(1, 0, 1, IDLE, 4);
    add(0, 0, 1, IDLE, 1);
    add(0, 0, 1, 9'b110_000_100, 1);
    add(0, 0, 1, 9'b100_000_100, 3);
    add(0, 0, 1, 9'b001_000_100, 1);
    add(0, 0, 1, IDLE, 3);

    // Reset held 2 cycles with pins toggling.
    reset = 1'b1;
    mosi_pin = 1'b1; sclk_pin = 1'b1; cs_pin = 1'b0;
    tick();
    check("reset_c0", outv, IDLE);
    mosi_pin = 1'b0; sclk_pin = 1'b1; cs_pin = 1'b1;
    tick();
    check("reset_c1", outv, IDLE);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      mosi_pin = vecs[i].mosi;
      sclk_pin = vecs[i].sclk;
      cs_pin   = vecs[i].cs;
      tick();
      check($sformatf("vec%0d", i), outv, vecs[i].exp);
    end

    // Transaction framing: CS low, 8 SCLK periods of 16 clk, CS high.
    reset_idle();
    n_csn = 0; n_csp = 0; n_sp = 0; n_sn = 0; n_viol = 0;
    cs_pin = 1'b0;
    repeat (10) tick_cnt();
    for (int p = 0; p < 8; p++) begin
      sclk_pin = 1'b1;
      repeat (8) tick_cnt();
      sclk_pin = 1'b0;
      repeat (8) tick_cnt();
    end
    repeat (10) tick_cnt();
    cs_pin = 1'b1;
    repeat (12) tick_cnt();
    check("frame_cs_negedge", n_csn, 1);
    check("frame_sclk_posedge", n_sp, 8);
    check("frame_sclk_negedge", n_sn, 8);
    check("frame_cs_posedge", n_csp, 1);
    check("frame_cs_low_in_burst", n_viol, 0);
    check("frame_end_state", outv, IDLE);

    // Reset while the SCLK counter sits at 2.
    reset_idle();
    sclk_pin = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("rst_mid_quiet", outv, IDLE);
    reset = 1'b0;
    idx_s = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (sclk_posedge === 1'b1) begin
        idx_s = k;
        break;
      end
    end
    check("rst_mid_pulse_edge", idx_s, 5);
    tick();
    check("rst_mid_after", outv, 9'b000_100_100);

    // All pins change together; CS only glitches for 2 cycles.
    reset_idle();
    idx_m = -1; idx_s = -1; cs_pulses = 0; cs_bad = 0;
    mosi_pin = 1'b1; sclk_pin = 1'b1; cs_pin = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) cs_pin = 1'b1;
      tick();
      if (mosi_posedge === 1'b1 && idx_m < 0) idx_m = k;
      if (sclk_posedge === 1'b1 && idx_s < 0) idx_s = k;
      cs_pulses += int'(cs_posedge) + int'(cs_negedge);
      if (cs_cond !== 1'b1) cs_bad++;
    end
    check("indep_mosi_edge", idx_m, 5);
    check("indep_sclk_edge", idx_s, 5);
    check("indep_cs_pulses", cs_pulses, 0);
    check("indep_cs_level", cs_bad, 0);
    check("indep_final", outv, 9'b100_100_100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_input_conditioner.md
# spi_input_conditioner

Front-end conditioning stage for the SPI slave datapath. Synchronizes, debounces and edge-detects the three asynchronous SPI pins (MOSI, SCLK, CS) in the system clock domain. Outputs feed the downstream SPI control FSM and the shift register directly:
- conditioned CS gates the transaction.
- SCLK positive-edge pulses drive serial capture and bit counting.
- SCLK negative-edge pulses drive MISO updates.

## Interface
Parameters:
- COUNTERWIDTH, default 3: width of each channel's debounce counter.
- WAITTIME, default 3: debounce threshold in cycles. Constraint: 1 ≤ WAITTIME ≤ 2^COUNTERWIDTH − 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mosi_pin  input  1  raw asynchronous MOSI.
- sclk_pin  input  1  raw asynchronous SCLK.
- cs_pin  input  1  raw asynchronous chip select, active low.
- mosi_cond  output  1  conditioned MOSI level.
- mosi_posedge  output  1  one-cycle pulse on a conditioned MOSI 0→1 transition.
- mosi_negedge  output  1  one-cycle pulse on a conditioned MOSI 1→0 transition.
- sclk_cond  output  1  conditioned SCLK level.
- sclk_posedge  output  1  one-cycle pulse on a conditioned SCLK 0→1 transition.
- sclk_negedge  output  1  one-cycle pulse on a conditioned SCLK 1→0 transition.
- cs_cond  output  1  conditioned CS level.
- cs_posedge  output  1  one-cycle pulse on a conditioned CS 0→1 transition (end of transaction).
- cs_negedge  output  1  one-cycle pulse on a conditioned CS 1→0 transition (start of transaction).

## Operation
- Three identical, fully independent channels. Per-channel state: sync1, sync2, counter[COUNTERWIDTH-1:0], cond, posedge, negedge.
- Synchronizer: sync1 <= pin; sync2 <= sync1, every cycle.
- Debounce, evaluated every rising edge:
  - sync2 == cond: counter <= 0; no level change.
  - sync2 != cond and counter != WAITTIME: counter <= counter + 1.
  - sync2 != cond and counter == WAITTIME: cond <= sync2; counter <= 0. The matching edge pulse is set: posedge if sync2 = 1, negedge if sync2 = 0.
- Edge pulses are registered outputs. They are cleared on every edge where no transition is committed, so each pulse is high for exactly one cycle.
- posedge and negedge of one channel are never high in the same cycle.
- Counter never exceeds WAITTIME. No wrap-around is possible.
- Reset (reset = 1 at a rising edge) has priority over all other updates:
  - Counters = 0; all pulses = 0.
  - MOSI and SCLK channels: sync1 = sync2 = cond = 0.
  - CS channel: sync1 = sync2 = cond = 1 (idle high).
  - Consequence: a pin held at its idle level through reset release produces no edge pulse.
- Reset asserted mid-count discards the pending transition. Counting restarts from 0 after reset release.
- Reset values of outputs: mosi_cond = 0, sclk_cond = 0, cs_cond = 1; all six edge outputs = 0.

## Timing
- Pin change sampled at rising edge E0 and held stable:
  - sync2 reflects it at E1.
  - counter = 1, 2, …, WAITTIME at E2 … E(WAITTIME+1).
  - cond and the edge pulse update at E(WAITTIME+2).
  - The pulse deasserts at E(WAITTIME+3).
- Defaults (WAITTIME = 3): 5-cycle level latency, pulse visible during the cycle after E5.
- Filtering: a level must be held at sync2 for WAITTIME+1 consecutive edges to commit. Any shorter excursion returns the counter to 0 and produces no output change.
- Minimum SPI pin high/low time for reliable detection: WAITTIME+2 clk periods. Downstream blocks must keep SCLK at or below clk/(2·(WAITTIME+2)).
- Channels are not skew-aligned. Simultaneous pin changes commit on the same edge only if all satisfy the debounce identically.

## Test plan
- Reset: hold reset 2 cycles with all pins toggling, then release with mosi_pin = 0, sclk_pin = 0, cs_pin = 1.
  - Required: mosi_cond = 0, sclk_cond = 0, cs_cond = 1, all edges 0, and no pulse in the 10 cycles after release.
- Clean SCLK edge (WAITTIME = 3): raise sclk_pin before edge E0 and hold.
  - Required: sclk_cond = 1 after E5; sclk_posedge = 1 only between E5 and E6; sclk_negedge stays 0.
  - Lowering sclk_pin gives the mirror behaviour on sclk_negedge.
- Glitch rejection: pulse mosi_pin high for 3 clk cycles, then low.
  - Required: mosi_cond stays 0, no pulses.
  - Repeat with 4 cycles: mosi_cond goes high once, mosi_posedge fires once, and after return to 0 mosi_negedge fires once.
- Transaction framing: drive cs_pin 1→0, run 8 SCLK periods of 16 clk cycles, then cs_pin 0→1.
  - Required: exactly one cs_negedge, eight sclk_posedge, eight sclk_negedge, one cs_posedge.
  - cs_cond is low throughout the SCLK burst.
- Reset mid-debounce: change sclk_pin to 1, assert reset at counter = 2, release with sclk_pin still 1.
  - Required: no pulse during reset.
  - sclk_posedge fires WAITTIME+2 edges after the first post-reset edge; sclk_cond = 1 thereafter.
- Channel independence: toggle all three pins on the same edge with a 2-cycle glitch on cs_pin only.
  - Required: mosi and sclk commit on the same edge; CS is unaffected.
